// File: rtl/uart_rx_os8_if.sv
// Serial-receive bundle between the baud generator / pin side and the byte consumer.
// Master drives the tick and the line; slave (the receiver) returns the byte and status.
// Carries no flow control: the consumer must take rx_data in the rx_done cycle or rely on the hold.
interface uart_rx_os8_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output baud_tick,
    output rx,
    input  rx_data,
    input  rx_done,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  baud_tick,
    input  rx,
    output rx_data,
    output rx_done,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx_os8.sv
// 8x-oversampled 8N1 UART receiver: sync, mid-bit start check, centre sampling, framing check.
// Latency: rx_done one clk after the stop-sample tick (T0+12+8*DATA_BITS ticks after detection).
// No backpressure: rx_done is a one-clk strobe, rx_data/frame_err hold until the next frame.
module uart_rx_os8 #(
  parameter int DATA_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  uart_rx_os8_if.slave bus
);

  localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  // BRK parks the receiver while the line is held low after a bad stop bit,
  // so a break condition cannot be mistaken for a new start bit.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_m, rx_s;
  logic [2:0]           tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  // Two-stage synchroniser on the asynchronous line; resets to the idle (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath: everything holds except on a baud_tick cycle;
  // rx_done defaults low so it can only ever be a single-cycle strobe.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (bus.baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end

        // Re-check the line half a bit after the falling edge; a high level
        // there means the edge was noise and nothing is reported.
        START: begin
          if (tick_q == 3'd3) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 3'd1;
          end
        end

        // Eight ticks per bit from mid-start lands every sample at bit centre.
        DATA: begin
          if (tick_q == 3'd7) begin
            sh_d   = {rx_s, sh_q[DATA_BITS-1:1]};
            tick_d = '0;
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + 3'd1;
          end
        end

        // Leaving at mid-stop-bit gives half a bit of slack for back-to-back
        // frames and for a transmitter running slightly fast.
        STOP: begin
          if (tick_q == 3'd7) begin
            data_d  = sh_q;
            err_d   = ~rx_s;
            done_d  = 1'b1;
            tick_d  = '0;
            state_d = rx_s ? IDLE : BRK;
          end else begin
            tick_d = tick_q + 3'd1;
          end
        end

        BRK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = err_q;
  assign bus.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os8.sv
// Scoreboard bench for uart_rx_os8: frames are driven on the serial line, the expected
// {frame_err, byte} goes into a queue at send time, and a monitor pops on every rx_done.
// Ticks run every 8 clk so one bit is 64 clk; skewed frames use 62/66 clk per bit.
module tb_uart_rx_os8;

  localparam int TP  = 8;
  localparam int BIT = TP * 8;

  logic clk;
  logic rst;

  uart_rx_os8_if #(.DATA_BITS(8)) bus ();

  uart_rx_os8 #(.DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          tdiv   = 0;
  int          tick_cyc[$];
  int          done_cyc[$];
  logic [8:0]  sb_q[$];
  int          last_start_cyc = 0;
  bit          timing_chk = 0;
  logic        prev_done = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edge counter and log of edges at which the DUT sees a tick.
  always @(posedge clk) begin
    cyc++;
    if (bus.baud_tick) tick_cyc.push_back(cyc);
  end

  // Baud tick generator: one-clk pulse every TP clocks.
  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tdiv = (tdiv == TP - 1) ? 0 : tdiv + 1;
      bus.baud_tick = (tdiv == 0);
    end
  end

  // Monitor: pops the expected response whenever the DUT strobes rx_done.
  always @(negedge clk) begin
    if (bus.rx_done) begin
      logic [8:0] exp;
      done_cyc.push_back(cyc);
      check("done_pulse_width", {31'd0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp[7:0]});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, exp[8]});
      end
      if (timing_chk) begin
        int n = 0;
        foreach (tick_cyc[i]) if (tick_cyc[i] >= last_start_cyc + 3 && tick_cyc[i] <= cyc) n++;
        check("done_after_tick", tick_cyc[$], cyc);
        check("ticks_T0_to_stop", n, 77);
      end
    end
    prev_done = bus.rx_done;
  end

  // Drives start, LSB-first data and the given stop level; leaves the line at the stop level.
  task automatic send_frame(input logic [7:0] b, input int bitp, input logic stop);
    sb_q.push_back({~stop, b});
    bus.rx = 1'b0;
    last_start_cyc = cyc;
    wait_clk(bitp);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wait_clk(bitp);
    end
    bus.rx = stop;
    wait_clk(bitp);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    wait_clk(n);
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation exceeded 80000 cycles, expected completion");
    $fatal(1);
  end

  initial begin
    int          nd;
    logic [7:0]  rb;
    int          bp;
    bit          bad;

    rst    = 1'b1;
    bus.rx = 1'b1;
    wait_clk(3);
    check("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("reset_rx_done", {31'd0, bus.rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
    rst = 1'b0;
    idle(3 * BIT);
    check("idle_busy", {31'd0, bus.rx_busy}, 32'd0);

    // Single byte with detection-to-strobe timing.
    timing_chk = 1;
    send_frame(8'h55, BIT, 1'b1);
    timing_chk = 0;
    idle(BIT);
    check("single_busy_after", {31'd0, bus.rx_busy}, 32'd0);
    idle(2 * BIT);

    // Back-to-back: strobes exactly ten bit-times apart.
    send_frame(8'hA5, BIT, 1'b1);
    send_frame(8'h3C, BIT, 1'b1);
    idle(2 * BIT);
    check("b2b_spacing", done_cyc[$] - done_cyc[$-1], 10 * BIT);

    // Glitch shorter than half a bit must be rejected silently.
    nd = done_cyc.size();
    bus.rx = 1'b0;
    wait_clk(2 * TP);
    idle(6 * TP);
    check("glitch_busy", {31'd0, bus.rx_busy}, 32'd0);
    idle(2 * BIT);
    check("glitch_no_done", done_cyc.size(), nd);
    send_frame(8'h81, BIT, 1'b1);
    idle(2 * BIT);

    // Framing error followed by a held-low line.
    send_frame(8'h00, BIT, 1'b0);
    wait_clk(3 * BIT);
    check("break_busy_held", {31'd0, bus.rx_busy}, 32'd1);
    idle(BIT);
    check("break_busy_released", {31'd0, bus.rx_busy}, 32'd0);
    send_frame(8'hFF, BIT, 1'b1);
    idle(2 * BIT);

    // Reset during data bit 3 of 0xC3; the transmitter is abandoned with it.
    nd = done_cyc.size();
    bus.rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 3; i++) begin
      bus.rx = rb_c3(i);
      wait_clk(BIT);
    end
    bus.rx = rb_c3(3);
    wait_clk(BIT / 2);
    rst = 1'b1;
    bus.rx = 1'b1;
    wait_clk(1);
    check("midreset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("midreset_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("midreset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    wait_clk(4);
    rst = 1'b0;
    idle(3 * BIT);
    check("midreset_no_done", done_cyc.size(), nd);
    send_frame(8'hC3, BIT, 1'b1);
    idle(2 * BIT);

    // Baud skew of about +/-3%.
    send_frame(8'h5A, BIT - 2, 1'b1);
    idle(2 * BIT);
    send_frame(8'h5A, BIT + 2, 1'b1);
    idle(2 * BIT);

    // Random traffic: random bytes, bit periods, gaps and occasional bad stop bits.
    for (int k = 0; k < 24; k++) begin
      rb  = 8'($urandom);
      bp  = $urandom_range(BIT - 2, BIT + 2);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(rb, bp, ~bad);
      if (bad) begin
        wait_clk($urandom_range(0, 2) * bp);
        idle(bp + $urandom_range(0, BIT));
      end else begin
        idle($urandom_range(0, BIT));
      end
    end
    idle(3 * BIT);

    check("scoreboard_drained", sb_q.size(), 0);
    check("final_busy", {31'd0, bus.rx_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic rb_c3(input int i);
    logic [7:0] v;
    v = 8'hC3;
    return v[i];
  endfunction

endmodule
